// File: rtl/score_keeper.sv
// score_keeper: match score state machine feeding the 7-segment score display.
// Raw point/new-game requests are synchronized, edge-detected and turned into
// registered scores with a post-point lockout and a frozen end-of-match state.
module score_keeper #(
  parameter int unsigned WIN_SCORE      = 5,
  parameter int unsigned LOCKOUT_CYCLES = 100
) (
  input  logic       segclk,
  input  logic       clr,
  input  logic       p1_pt,
  input  logic       p2_pt,
  input  logic       new_game,
  output logic [2:0] p1,
  output logic [2:0] p2,
  output logic       game_over,
  output logic       winner,
  output logic       scored
);

  localparam int unsigned SW  = 3;
  localparam int unsigned CW  = 8;
  localparam int unsigned NIN = 3;

  localparam logic [SW-1:0] WIN_VAL   = SW'(WIN_SCORE);
  localparam logic [SW-1:0] SCORE_ONE = SW'(1);
  localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Input bit positions inside the synchronizer vectors
  localparam int unsigned IDX_P1 = 0;
  localparam int unsigned IDX_P2 = 1;
  localparam int unsigned IDX_NG = 2;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    LOCK = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  lock_cnt, cnt_nxt;
  logic [SW-1:0]  p1_nxt, p2_nxt;
  logic [SW-1:0]  p1_inc, p2_inc;
  logic           go_nxt, win_nxt, sc_nxt;

  logic [NIN-1:0] sync1, sync2, hist;
  logic [NIN-1:0] rise;
  logic           p1_rise, p2_rise, ng_rise;

  // Two-flop synchronizers plus history flop; reset high so a held level never fires
  always_ff @(posedge segclk or posedge clr) begin
    if (clr) begin
      sync1 <= '1;
      sync2 <= '1;
      hist  <= '1;
    end else begin
      sync1 <= {new_game, p2_pt, p1_pt};
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise    = sync2 & ~hist;
  assign p1_rise = rise[IDX_P1];
  assign p2_rise = rise[IDX_P2];
  assign ng_rise = rise[IDX_NG];

  // State, lockout counter and registered outputs
  always_ff @(posedge segclk or posedge clr) begin
    if (clr) begin
      state     <= PLAY;
      lock_cnt  <= '0;
      p1        <= '0;
      p2        <= '0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      scored    <= 1'b0;
    end else begin
      state     <= state_nxt;
      lock_cnt  <= cnt_nxt;
      p1        <= p1_nxt;
      p2        <= p2_nxt;
      game_over <= go_nxt;
      winner    <= win_nxt;
      scored    <= sc_nxt;
    end
  end

  // Next-state and next-output decode; new_game overrides everything
  always_comb begin
    state_nxt = state;
    cnt_nxt   = lock_cnt;
    p1_nxt    = p1;
    p2_nxt    = p2;
    go_nxt    = game_over;
    win_nxt   = winner;
    sc_nxt    = 1'b0;
    p1_inc    = p1 + SCORE_ONE;
    p2_inc    = p2 + SCORE_ONE;

    if (ng_rise) begin
      state_nxt = PLAY;
      cnt_nxt   = '0;
      p1_nxt    = '0;
      p2_nxt    = '0;
      go_nxt    = 1'b0;
      win_nxt   = 1'b0;
    end else begin
      case (state)
        PLAY: begin
          if (p1_rise && !p2_rise) begin
            p1_nxt = p1_inc;
            sc_nxt = 1'b1;
            if (p1_inc == WIN_VAL) begin
              state_nxt = OVER;
              go_nxt    = 1'b1;
              win_nxt   = 1'b0;
            end else begin
              state_nxt = LOCK;
              cnt_nxt   = LOCK_LOAD;
            end
          end else if (p2_rise && !p1_rise) begin
            p2_nxt = p2_inc;
            sc_nxt = 1'b1;
            if (p2_inc == WIN_VAL) begin
              state_nxt = OVER;
              go_nxt    = 1'b1;
              win_nxt   = 1'b1;
            end else begin
              state_nxt = LOCK;
              cnt_nxt   = LOCK_LOAD;
            end
          end else if (p1_rise && p2_rise) begin
            // Disputed point: nobody scores but the lockout still applies
            state_nxt = LOCK;
            cnt_nxt   = LOCK_LOAD;
          end
        end
        LOCK: begin
          if (lock_cnt == '0) begin
            state_nxt = PLAY;
          end else begin
            cnt_nxt = lock_cnt - CNT_ONE;
          end
        end
        OVER: begin
          state_nxt = OVER;
        end
        default: begin
          state_nxt = PLAY;
        end
      endcase
    end
  end

endmodule
